udma_ch_remap: RTL and testbench

Runtime-programmable channel map for the uDMA core: the successor to fixed, elaboration-time channel IDs. Software programs, per peripheral, a base channel and channel count for the TX and RX linear channel banks through a small config bus. A scan FSM validates the table and builds per-channel owner vectors. Only conflict-free tables are committed; the active map is double-buffered so channel muxing in the uDMA core never sees a half-updated map.

---
 rtl/udma_ch_remap_pkg.sv | 53 +++++
 rtl/udma_ch_remap_claim.sv | 46 ++++
 rtl/udma_ch_remap.sv | 274 +++++++++++++++++++++++++++
 tb/tb_udma_ch_remap.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/udma_ch_remap_pkg.sv
// udma_ch_remap_pkg
//   Shared definitions for the runtime-programmable uDMA channel map:
//   config-bus address constants, entry/status/control field offsets,
//   the channel-map entry record and the scan FSM state type.
//   Entry word packing helpers keep the bus layout in one place.
package udma_ch_remap_pkg;

    // Address decode
    localparam logic [5:0] REG_STATUS     = 6'h20;
    localparam int         ADDR_ENTRY_BIT = 5;     // 0 selects an entry register
    localparam int         ADDR_DIR_BIT   = 4;     // 0 = TX bank, 1 = RX bank

    // Entry word layout
    localparam int ENT_BASE_LSB = 0;
    localparam int ENT_CNT_LSB  = 8;
    localparam int ENT_EN_BIT   = 31;

    // STATUS read fields
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_CONF_BIT = 1;
    localparam int STAT_LOCK_BIT = 2;
    localparam int STAT_IDX_LSB  = 8;

    // CTRL write fields
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_LOCK_BIT   = 1;

    typedef struct packed {
        logic       en;
        logic [7:0] cnt;
        logic [7:0] base;
    } ch_entry_t;

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} scan_state_t;

    function automatic ch_entry_t entry_from_word(input logic [31:0] w);
        ch_entry_t e;
        e.en   = w[ENT_EN_BIT];
        e.cnt  = w[ENT_CNT_LSB +: 8];
        e.base = w[ENT_BASE_LSB +: 8];
        return e;
    endfunction

    function automatic logic [31:0] entry_to_word(input ch_entry_t e);
        logic [31:0] w;
        w                    = '0;
        w[ENT_EN_BIT]        = e.en;
        w[ENT_CNT_LSB +: 8]  = e.cnt;
        w[ENT_BASE_LSB +: 8] = e.base;
        return w;
    endfunction

endpackage

// File: rtl/udma_ch_remap_claim.sv
// udma_ch_claim
//   Combinational claimant counter for one channel of one direction bank.
//   Ports:
//     chan    - channel index local to the bank
//     entries - per-peripheral entries of that bank
//     owner   - lowest-numbered claiming peripheral (0 when none)
//     hit     - at least one peripheral claims the channel
//     multi   - two or more peripherals claim the channel
module udma_ch_claim
    import udma_ch_remap_pkg::*;
#(
    parameter int N_PERIPHS = 8,
    parameter int PID_W     = 3
) (
    input  logic [7:0]                  chan,
    input  ch_entry_t [N_PERIPHS-1:0]   entries,
    output logic [PID_W-1:0]            owner,
    output logic                        hit,
    output logic                        multi
);

    logic [N_PERIPHS-1:0] hits;

    // Range end is formed at 9 bits so base+count never wraps.
    generate
        for (genvar gi = 0; gi < N_PERIPHS; gi++) begin : g_hit
            assign hits[gi] = entries[gi].en
                && ({1'b0, chan} >= {1'b0, entries[gi].base})
                && ({1'b0, chan} <  ({1'b0, entries[gi].base} + {1'b0, entries[gi].cnt}));
        end
    endgenerate

    always_comb begin
        owner = '0;
        for (int i = N_PERIPHS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                owner = PID_W'(i);
            end
        end
    end

    assign hit   = |hits;
    // Clearing the lowest set bit leaves something only if >=2 bits were set.
    assign multi = (hits & (hits - N_PERIPHS'(1))) != '0;

endmodule

// File: rtl/udma_ch_remap.sv
// udma_ch_remap
//   Runtime-programmable TX/RX channel map for the uDMA core. Software
//   writes per-peripheral {base, count, enable} entries into a shadow table,
//   then commits. A scan walks every global channel once, stages owners and
//   detects overlaps/out-of-range entries; only a clean scan is copied to the
//   active map, all channels in one cycle.
//   Ports:
//     clk_i, rst_i         - clock, synchronous active-high reset
//     cfg_*                - config bus (req/gnt, 1-cycle registered response)
//     tx_owner_o/_valid_o  - active owner map of the TX bank
//     rx_owner_o/_valid_o  - active owner map of the RX bank
//     busy_o               - scan in progress
//     conflict_o           - last commit rejected
//   Build option: UDMA_CH_REMAP_LOCK_EN adds a sticky lock (STATUS wdata[1]).
module udma_ch_remap
    import udma_ch_remap_pkg::*;
#(
    parameter int N_PERIPHS = 8,
    parameter int N_TX_CH   = 8,
    parameter int N_RX_CH   = 6,
    parameter int PID_W     = (N_PERIPHS > 1) ? $clog2(N_PERIPHS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_req_i,
    output logic                       cfg_gnt_o,
    input  logic                       cfg_wen_i,
    input  logic [5:0]                 cfg_addr_i,
    input  logic [31:0]                cfg_wdata_i,
    output logic [31:0]                cfg_rdata_o,
    output logic                       cfg_rvalid_o,
    output logic [N_TX_CH*PID_W-1:0]   tx_owner_o,
    output logic [N_TX_CH-1:0]         tx_owner_valid_o,
    output logic [N_RX_CH*PID_W-1:0]   rx_owner_o,
    output logic [N_RX_CH-1:0]         rx_owner_valid_o,
    output logic                       busy_o,
    output logic                       conflict_o
);

    localparam int             N_TOT  = N_TX_CH + N_RX_CH;
    localparam int             CW     = (N_TOT > 1) ? $clog2(N_TOT) : 1;
    localparam logic [CW-1:0]  C_TX   = CW'(N_TX_CH);
    localparam logic [CW-1:0]  C_LAST = CW'(N_TOT - 1);

    scan_state_t               state_reg;
    logic [CW-1:0]             c_reg;
    logic                      scan_bad_reg;
    logic                      conflict_reg;
    logic [7:0]                conf_idx_reg;
    ch_entry_t [N_PERIPHS-1:0] tx_tab_reg;
    ch_entry_t [N_PERIPHS-1:0] rx_tab_reg;
    logic [PID_W-1:0]          stage_owner_reg [N_TOT];
    logic [N_TOT-1:0]          stage_valid_reg;
    logic [PID_W-1:0]          tx_owner_reg [N_TX_CH];
    logic [PID_W-1:0]          rx_owner_reg [N_RX_CH];
    logic [N_TX_CH-1:0]        tx_valid_reg;
    logic [N_RX_CH-1:0]        rx_valid_reg;
    logic                      rvalid_reg;
    logic [31:0]               rdata_reg;

    // ---------------- config decode ----------------
    logic       busy;
    logic       wr_acc;
    logic       is_entry;
    logic       is_rx;
    logic       is_status;
    logic [3:0] pidx;
    logic       locked;
    logic       entry_wr;
    logic       commit;

    assign busy      = (state_reg != IDLE);
    // Writes stall during a scan so the shadow table stays frozen under it.
    assign cfg_gnt_o = cfg_req_i & ~rst_i & ~(cfg_wen_i & busy);
    assign wr_acc    = cfg_gnt_o & cfg_wen_i;
    assign is_entry  = ~cfg_addr_i[ADDR_ENTRY_BIT];
    assign is_rx     = cfg_addr_i[ADDR_DIR_BIT];
    assign is_status = (cfg_addr_i == REG_STATUS);
    assign pidx      = cfg_addr_i[3:0];
    assign entry_wr  = wr_acc & is_entry & ~locked;
    assign commit    = wr_acc & is_status & cfg_wdata_i[CTRL_COMMIT_BIT] & ~locked;

`ifdef UDMA_CH_REMAP_LOCK_EN
    logic lock_reg;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_reg <= 1'b0;
        end else if (wr_acc & is_status & cfg_wdata_i[CTRL_LOCK_BIT]) begin
            lock_reg <= 1'b1;
        end
    end
    assign locked = lock_reg;
`else
    logic unused_lock_bit;
    assign unused_lock_bit = cfg_wdata_i[CTRL_LOCK_BIT];
    assign locked          = 1'b0;
`endif

    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata_i[30:16];

    // ---------------- shadow table ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_tab_reg <= '0;
            rx_tab_reg <= '0;
        end else if (entry_wr) begin
            // Indices beyond N_PERIPHS never match and are dropped.
            for (int p = 0; p < N_PERIPHS; p++) begin
                if (pidx == 4'(p)) begin
                    if (is_rx) rx_tab_reg[p] <= entry_from_word(cfg_wdata_i);
                    else       tx_tab_reg[p] <= entry_from_word(cfg_wdata_i);
                end
            end
        end
    end

    // ---------------- scan datapath ----------------
    logic                      scan_is_tx;
    logic [7:0]                c_local;
    ch_entry_t [N_PERIPHS-1:0] scan_tab;
    logic [PID_W-1:0]          claim_owner;
    logic                      claim_hit;
    logic                      claim_multi;
    logic [N_PERIPHS-1:0]      tx_rng_bad;
    logic [N_PERIPHS-1:0]      rx_rng_bad;
    logic                      first_c;
    logic                      rng_tx;
    logic                      rng_rx;

    assign scan_is_tx = (c_reg < C_TX);
    assign c_local    = scan_is_tx ? 8'(c_reg) : 8'(c_reg - C_TX);
    assign scan_tab   = scan_is_tx ? tx_tab_reg : rx_tab_reg;

    udma_ch_claim #(
        .N_PERIPHS (N_PERIPHS),
        .PID_W     (PID_W)
    ) u_claim (
        .chan    (c_local),
        .entries (scan_tab),
        .owner   (claim_owner),
        .hit     (claim_hit),
        .multi   (claim_multi)
    );

    generate
        for (genvar gi = 0; gi < N_PERIPHS; gi++) begin : g_rng
            assign tx_rng_bad[gi] = tx_tab_reg[gi].en &&
                (({1'b0, tx_tab_reg[gi].base} + {1'b0, tx_tab_reg[gi].cnt}) > 9'(N_TX_CH));
            assign rx_rng_bad[gi] = rx_tab_reg[gi].en &&
                (({1'b0, rx_tab_reg[gi].base} + {1'b0, rx_tab_reg[gi].cnt}) > 9'(N_RX_CH));
        end
    endgenerate

    // Range violations are evaluated once, on the first scan cycle.
    assign first_c = (c_reg == '0);
    assign rng_tx  = first_c & (|tx_rng_bad);
    assign rng_rx  = first_c & (|rx_rng_bad);

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            c_reg        <= '0;
            scan_bad_reg <= 1'b0;
            conflict_reg <= 1'b0;
            conf_idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (commit) begin
                        state_reg    <= SCAN;
                        c_reg        <= '0;
                        scan_bad_reg <= 1'b0;
                        conflict_reg <= 1'b0;
                        conf_idx_reg <= '0;
                    end
                end
                SCAN: begin
                    // Keep the index of the earliest-detected conflict only.
                    if (!scan_bad_reg) begin
                        if (claim_multi)  conf_idx_reg <= 8'(c_reg);
                        else if (rng_tx)  conf_idx_reg <= 8'(N_TX_CH);
                        else if (rng_rx)  conf_idx_reg <= 8'(N_TOT);
                    end
                    if (claim_multi | rng_tx | rng_rx) begin
                        scan_bad_reg <= 1'b1;
                    end
                    if (c_reg == C_LAST) state_reg <= FINISH;
                    else                 c_reg     <= c_reg + CW'(1);
                end
                FINISH: begin
                    conflict_reg <= scan_bad_reg;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ---------------- staging and active map ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_TOT; i++)   stage_owner_reg[i] <= '0;
            for (int i = 0; i < N_TX_CH; i++) tx_owner_reg[i]    <= '0;
            for (int i = 0; i < N_RX_CH; i++) rx_owner_reg[i]    <= '0;
            stage_valid_reg <= '0;
            tx_valid_reg    <= '0;
            rx_valid_reg    <= '0;
        end else begin
            if (state_reg == SCAN) begin
                for (int i = 0; i < N_TOT; i++) begin
                    if (c_reg == CW'(i)) begin
                        stage_valid_reg[i] <= claim_hit & ~claim_multi;
                        stage_owner_reg[i] <= (claim_hit & ~claim_multi) ? claim_owner : '0;
                    end
                end
            end
            if (state_reg == FINISH && !scan_bad_reg) begin
                for (int i = 0; i < N_TX_CH; i++) tx_owner_reg[i] <= stage_owner_reg[i];
                for (int i = 0; i < N_RX_CH; i++) rx_owner_reg[i] <= stage_owner_reg[N_TX_CH + i];
                tx_valid_reg <= stage_valid_reg[N_TX_CH-1:0];
                rx_valid_reg <= stage_valid_reg[N_TOT-1:N_TX_CH];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_TX_CH; gi++) begin : g_tx_out
            assign tx_owner_o[gi*PID_W +: PID_W] = tx_owner_reg[gi];
        end
        for (genvar gi = 0; gi < N_RX_CH; gi++) begin : g_rx_out
            assign rx_owner_o[gi*PID_W +: PID_W] = rx_owner_reg[gi];
        end
    endgenerate

    assign tx_owner_valid_o = tx_valid_reg;
    assign rx_owner_valid_o = rx_valid_reg;
    assign busy_o           = busy;
    assign conflict_o       = conflict_reg;

    // ---------------- read path and response ----------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (is_entry) begin
            for (int p = 0; p < N_PERIPHS; p++) begin
                if (pidx == 4'(p)) begin
                    rd_val = entry_to_word(is_rx ? rx_tab_reg[p] : tx_tab_reg[p]);
                end
            end
        end else if (is_status) begin
            rd_val[STAT_BUSY_BIT]      = busy;
            rd_val[STAT_CONF_BIT]      = conflict_reg;
            rd_val[STAT_LOCK_BIT]      = locked;
            rd_val[STAT_IDX_LSB +: 8]  = conf_idx_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= cfg_gnt_o;
            rdata_reg  <= (cfg_gnt_o & ~cfg_wen_i) ? rd_val : '0;
        end
    end

    assign cfg_rvalid_o = rvalid_reg;
    assign cfg_rdata_o  = rdata_reg;

endmodule

// File: tb/tb_udma_ch_remap.sv
// tb_udma_ch_remap
//   Directed bench for udma_ch_remap (default 8 periphs, 8 TX, 6 RX channels).
//   Honours UDMA_CH_REMAP_LOCK_EN for the lock scenario.
module tb_udma_ch_remap;

    logic        clk;
    logic        rst;
    logic        cfg_req;
    logic        cfg_gnt;
    logic        cfg_wen;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cfg_rvalid;
    logic [23:0] tx_owner;
    logic [7:0]  tx_valid;
    logic [17:0] rx_owner;
    logic [5:0]  rx_valid;
    logic        busy;
    logic        conflict;

    int total = 0;
    int bad   = 0;

    udma_ch_remap dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_req_i        (cfg_req),
        .cfg_gnt_o        (cfg_gnt),
        .cfg_wen_i        (cfg_wen),
        .cfg_addr_i       (cfg_addr),
        .cfg_wdata_i      (cfg_wdata),
        .cfg_rdata_o      (cfg_rdata),
        .cfg_rvalid_o     (cfg_rvalid),
        .tx_owner_o       (tx_owner),
        .tx_owner_valid_o (tx_valid),
        .rx_owner_o       (rx_owner),
        .rx_owner_valid_o (rx_valid),
        .busy_o           (busy),
        .conflict_o       (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One config access; returns at the negedge of the response cycle.
    task automatic cfg_xfer(input logic wen, input logic [5:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        int n;
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_wen = wen; cfg_addr = addr; cfg_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!cfg_gnt && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("gnt_wait", cfg_gnt, 1'b1);
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_wen = 1'b0;
        @(negedge clk);
        check("rvalid", cfg_rvalid, 1'b1);
        rdata = cfg_rdata;
        if (wen) check("wr_rdata", rdata, 32'h0);
        $display("xfer wen=%0d addr=%02h wdata=%08h rdata=%08h wait=%0d", wen, addr, wdata, rdata, n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("wait_idle", busy, 1'b0);
    endtask

    logic [31:0] rd;
    int          stalls;
    logic        gnt_in_busy;

    initial begin
        rst = 1'b1; cfg_req = 1'b0; cfg_wen = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", cfg_gnt, 1'b0);
        check("rst_rvalid", cfg_rvalid, 1'b0);
        check("rst_rdata", cfg_rdata, 32'h0);
        check("rst_txv", tx_valid, 8'h0);
        check("rst_rxv", rx_valid, 6'h0);
        check("rst_txo", tx_owner, 24'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_conf", conflict, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // Program TX p0 {0,2}, p1 {2,3}; out-of-range index and bad address.
        cfg_xfer(1'b1, 6'h00, 32'h8000_0200, rd);
        cfg_xfer(1'b1, 6'h01, 32'h8000_0302, rd);
        cfg_xfer(1'b1, 6'h0A, 32'h8000_0101, rd);
        cfg_xfer(1'b0, 6'h01, 32'h0, rd);
        check("rd_p1", rd, 32'h8000_0302);
        cfg_xfer(1'b0, 6'h0A, 32'h0, rd);
        check("rd_idx10", rd, 32'h0);
        cfg_xfer(1'b0, 6'h21, 32'h0, rd);
        check("rd_21", rd, 32'h0);
        check("shadow_only", tx_valid, 8'h0);

        // Commit with exact latency: response cycle is T+1, map at T+16.
        cfg_xfer(1'b1, 6'h20, 32'h1, rd);
        check("busy_t1", busy, 1'b1);
        repeat (14) @(negedge clk);
        check("busy_finish", busy, 1'b1);
        check("map_not_yet", tx_valid, 8'h0);
        @(negedge clk);
        check("busy_done", busy, 1'b0);
        check("c1_txo", tx_owner, 24'h001240);
        check("c1_txv", tx_valid, 8'h1F);
        check("c1_rxv", rx_valid, 6'h0);
        check("c1_conf", conflict, 1'b0);
        cfg_xfer(1'b0, 6'h20, 32'h0, rd);
        check("c1_status", rd, 32'h0);

        // Overlap: TX p2 {1,2} collides with p0 on channel 1.
        cfg_xfer(1'b1, 6'h02, 32'h8000_0201, rd);
        cfg_xfer(1'b1, 6'h20, 32'h1, rd);
        wait_idle();
        check("c2_conf", conflict, 1'b1);
        cfg_xfer(1'b0, 6'h20, 32'h0, rd);
        check("c2_status", rd, 32'h0000_0102);
        check("c2_txo_kept", tx_owner, 24'h001240);
        check("c2_txv_kept", tx_valid, 8'h1F);

        // Range: RX p3 {4,3} runs past 6 RX channels -> index 14.
        cfg_xfer(1'b1, 6'h02, 32'h0, rd);
        cfg_xfer(1'b1, 6'h13, 32'h8000_0304, rd);
        cfg_xfer(1'b1, 6'h20, 32'h1, rd);
        wait_idle();
        check("c3_conf", conflict, 1'b1);
        cfg_xfer(1'b0, 6'h20, 32'h0, rd);
        check("c3_status", rd, 32'h0000_0E02);
        check("c3_rxv_kept", rx_valid, 6'h0);

        // Legal RX p3 {4,2}; a write issued during the scan must stall.
        cfg_xfer(1'b1, 6'h13, 32'h8000_0204, rd);
        cfg_xfer(1'b1, 6'h20, 32'h1, rd);
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_wen = 1'b1; cfg_addr = 6'h14; cfg_wdata = 32'h8000_0100;
        stalls = 0;
        gnt_in_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            stalls++;
            if (cfg_gnt) gnt_in_busy = 1'b1;
        end
        check("stall_gnt", gnt_in_busy, 1'b0);
        check("stall_cycles", stalls, 14);
        check("gnt_after_busy", cfg_gnt, 1'b1);
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_wen = 1'b0;
        @(negedge clk);
        check("stall_rvalid", cfg_rvalid, 1'b1);
        $display("xfer wen=1 addr=14 wdata=80000100 rdata=%08h wait=%0d", cfg_rdata, stalls);
        check("c4_rxo", rx_owner, 18'h1B000);
        check("c4_rxv", rx_valid, 6'h30);
        check("c4_txo", tx_owner, 24'h001240);
        check("c4_conf", conflict, 1'b0);
        cfg_xfer(1'b0, 6'h14, 32'h0, rd);
        check("rd_rx_p4", rd, 32'h8000_0100);

        // Reset during the 5th scan cycle.
        cfg_xfer(1'b1, 6'h20, 32'h1, rd);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("busy_before_rst", busy, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_txv", tx_valid, 8'h0);
        check("mid_rst_rxv", rx_valid, 6'h0);
        check("mid_rst_rxo", rx_owner, 18'h0);
        check("mid_rst_busy", busy, 1'b0);
        cfg_xfer(1'b0, 6'h00, 32'h0, rd);
        check("mid_rst_entry", rd, 32'h0);

        // Count=0 entry is legal; then the lock scenario.
        cfg_xfer(1'b1, 6'h00, 32'h8000_0200, rd);
        cfg_xfer(1'b1, 6'h01, 32'h8000_0005, rd);
        cfg_xfer(1'b1, 6'h20, 32'h1, rd);
        wait_idle();
        check("cnt0_txv", tx_valid, 8'h03);
        check("cnt0_conf", conflict, 1'b0);
        cfg_xfer(1'b1, 6'h20, 32'h2, rd);
`ifdef UDMA_CH_REMAP_LOCK_EN
        cfg_xfer(1'b0, 6'h20, 32'h0, rd);
        check("lock_status", rd, 32'h4);
        cfg_xfer(1'b1, 6'h00, 32'h8000_0400, rd);
        cfg_xfer(1'b0, 6'h00, 32'h0, rd);
        check("lock_entry_kept", rd, 32'h8000_0200);
        cfg_xfer(1'b1, 6'h20, 32'h1, rd);
        check("lock_no_busy", busy, 1'b0);
        repeat (16) @(negedge clk);
        check("lock_txv", tx_valid, 8'h03);
`else
        cfg_xfer(1'b0, 6'h20, 32'h0, rd);
        check("nolock_status", rd, 32'h0);
        cfg_xfer(1'b1, 6'h00, 32'h8000_0400, rd);
        cfg_xfer(1'b1, 6'h20, 32'h1, rd);
        check("nolock_busy", busy, 1'b1);
        wait_idle();
        check("nolock_txv", tx_valid, 8'h0F);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
